// File: rtl/decode_cycle.sv
// decode_cycle: instruction decode stage of a 5-stage RV32I pipeline.
//
// Decodes InstrD, reads the 32x32 register file (write port driven by
// writeback) and extends the immediate. All results are captured in the
// ID/EX pipeline register.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   InstrD, PCD,         IF/ID inputs: instruction, its PC and PC+4
//   PCPlus4D
//   RegWriteW, RDW,      register-file write port from writeback
//   ResultW
//   FlushE               synchronous bubble insert into ID/EX
//   Rs1D, Rs2D           combinational source indices for the hazard unit
//   *E outputs           registered ID/EX control, data and register indices
module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RdE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E
);

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } idex_t;

  // Immediate extension; every format sign-extends from instr[31].
  function automatic logic [31:0] imm_extend(input logic [31:0] instr, input logic [1:0] imm_src);
    logic [31:0] imm;
    case (imm_src)
      2'b00:   imm = {{20{instr[31]}}, instr[31:20]};
      2'b01:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      2'b10:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      2'b11:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

  // ALU decoder; sub is only chosen for R-type (op[5]=1) with funct7[5]=1.
  function automatic logic [2:0] alu_decode(input logic [1:0] alu_op, input logic [2:0] funct3,
                                            input logic op5, input logic funct7_5);
    logic [2:0] ctl;
    case (alu_op)
      2'b01: ctl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ctl = ({op5, funct7_5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  ctl = 3'b101;
          3'b110:  ctl = 3'b011;
          3'b111:  ctl = 3'b010;
          default: ctl = 3'b000;
        endcase
      end
      default: ctl = 3'b000;
    endcase
    return ctl;
  endfunction

  logic [6:0]  opcode_s;
  logic [4:0]  rd_s;
  logic        reg_write_s;
  logic [1:0]  imm_src_s;
  logic        alu_src_s;
  logic        mem_write_s;
  logic [1:0]  result_src_s;
  logic        branch_s;
  logic [1:0]  alu_op_s;
  logic        jump_s;
  logic        wb_en_s;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  idex_t       idex_d;
  idex_t       idex_q;

  assign opcode_s = InstrD[6:0];
  assign rd_s     = InstrD[11:7];
  assign Rs1D     = InstrD[19:15];
  assign Rs2D     = InstrD[24:20];
  // Writes to x0 are dropped entirely, so they never bypass either.
  assign wb_en_s  = RegWriteW && (RDW != 5'd0);

  // Main decoder: opcode to control fields; unknown opcodes decode as a bubble.
  always_comb begin
    reg_write_s  = 1'b0;
    imm_src_s    = 2'b00;
    alu_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    result_src_s = 2'b00;
    branch_s     = 1'b0;
    alu_op_s     = 2'b00;
    jump_s       = 1'b0;
    case (opcode_s)
      7'b0000011: begin
        reg_write_s = 1'b1; alu_src_s = 1'b1; result_src_s = 2'b01;
      end
      7'b0100011: begin
        imm_src_s = 2'b01; alu_src_s = 1'b1; mem_write_s = 1'b1;
      end
      7'b0110011: begin
        reg_write_s = 1'b1; alu_op_s = 2'b10;
      end
      7'b0010011: begin
        reg_write_s = 1'b1; alu_src_s = 1'b1; alu_op_s = 2'b10;
      end
      7'b1100011: begin
        imm_src_s = 2'b10; branch_s = 1'b1; alu_op_s = 2'b01;
      end
      7'b1101111: begin
        reg_write_s = 1'b1; imm_src_s = 2'b11; result_src_s = 2'b10; jump_s = 1'b1;
      end
      default: begin
        reg_write_s = 1'b0;
      end
    endcase
  end

  // Register-file next state: single write port from writeback.
  always_comb begin
    rf_d = rf_q;
    if (wb_en_s) begin
      rf_d[RDW] = ResultW;
    end else begin
      rf_d[RDW] = rf_q[RDW];
    end
  end

  // Register-file storage, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
    end
  end

  // Read ports: x0 is hard zero, then write-first bypass, then storage.
  always_comb begin
    if (Rs1D == 5'd0) begin
      rd1_s = 32'd0;
    end else if (wb_en_s && (RDW == Rs1D)) begin
      rd1_s = ResultW;
    end else begin
      rd1_s = rf_q[Rs1D];
    end
    if (Rs2D == 5'd0) begin
      rd2_s = 32'd0;
    end else if (wb_en_s && (RDW == Rs2D)) begin
      rd2_s = ResultW;
    end else begin
      rd2_s = rf_q[Rs2D];
    end
  end

  // ID/EX next state; a flush loads the all-zero bubble.
  always_comb begin
    idex_d = {$bits(idex_t){1'b0}};
    if (FlushE) begin
      idex_d = {$bits(idex_t){1'b0}};
    end else begin
      idex_d.reg_write   = reg_write_s;
      idex_d.mem_write   = mem_write_s;
      idex_d.jump        = jump_s;
      idex_d.branch      = branch_s;
      idex_d.alu_src     = alu_src_s;
      idex_d.result_src  = result_src_s;
      idex_d.alu_control = alu_decode(alu_op_s, InstrD[14:12], opcode_s[5], InstrD[30]);
      idex_d.rd1         = rd1_s;
      idex_d.rd2         = rd2_s;
      idex_d.imm_ext     = imm_extend(InstrD, imm_src_s);
      idex_d.pc          = PCD;
      idex_d.pc_plus4    = PCPlus4D;
      idex_d.rd          = rd_s;
      idex_d.rs1         = Rs1D;
      idex_d.rs2         = Rs2D;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q <= {$bits(idex_t){1'b0}};
    end else begin
      idex_q <= idex_d;
    end
  end

  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUSrcE     = idex_q.alu_src;
  assign ResultSrcE  = idex_q.result_src;
  assign ALUControlE = idex_q.alu_control;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm_ext;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;
  assign RdE         = idex_q.rd;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: a reference model predicts the ID/EX contents for
// every driven cycle into a queue; a monitor pops and compares after each
// capture edge. Directed checks with hand-derived constants cover reset,
// bypass, x0, branch immediate and flush behaviour.
module tb_decode_cycle;

  logic        clk;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RDW;
  logic [4:0]  Rs1D, Rs2D, RdE, Rs1E, Rs2E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  typedef struct packed {
    logic        rw, mw, j, br, asrc;
    logic [1:0]  rsrc;
    logic [2:0]  actl;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rd, rs1, rs2;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] tb_rf [32];
  logic [31:0] pc_v;
  int          n_checks;
  int          n_pass;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic wr,
                                           input logic [4:0] rdw, input logic [31:0] res);
    if (idx == 5'd0) return 32'd0;
    if (wr && rdw != 5'd0 && rdw == idx) return res;
    return tb_rf[idx];
  endfunction

  // Reference model: control word {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump}.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input logic wr,
                                 input logic [4:0] rdw, input logic [31:0] res, input logic flush);
    exp_t        e;
    logic [10:0] cw;
    logic [1:0]  isrc, aop;
    e = '0;
    case (i[6:0])
      7'b0000011: cw = 11'b1_00_1_0_01_0_00_0;
      7'b0100011: cw = 11'b0_01_1_1_00_0_00_0;
      7'b0110011: cw = 11'b1_00_0_0_00_0_10_0;
      7'b0010011: cw = 11'b1_00_1_0_00_0_10_0;
      7'b1100011: cw = 11'b0_10_0_0_00_1_01_0;
      7'b1101111: cw = 11'b1_11_0_0_10_0_00_1;
      default:    cw = 11'd0;
    endcase
    if (flush) return e;
    e.rw = cw[10]; isrc = cw[9:8]; e.asrc = cw[7]; e.mw = cw[6];
    e.rsrc = cw[5:4]; e.br = cw[3]; aop = cw[2:1]; e.j = cw[0];
    if (aop == 2'b01) e.actl = 3'b001;
    else if (aop == 2'b10) begin
      case (i[14:12])
        3'b000:  e.actl = (i[5] && i[30]) ? 3'b001 : 3'b000;
        3'b010:  e.actl = 3'b101;
        3'b110:  e.actl = 3'b011;
        3'b111:  e.actl = 3'b010;
        default: e.actl = 3'b000;
      endcase
    end else e.actl = 3'b000;
    case (isrc)
      2'b00:   e.imm = {{20{i[31]}}, i[31:20]};
      2'b01:   e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10:   e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
    e.rd1 = ref_read(i[19:15], wr, rdw, res);
    e.rd2 = ref_read(i[24:20], wr, rdw, res);
    e.pc = pc; e.pc4 = pc + 32'd4;
    e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    return e;
  endfunction

  // Drive one decode cycle and push its predicted ID/EX contents.
  task automatic cyc(input logic [31:0] instr, input logic wr, input logic [4:0] rdw,
                     input logic [31:0] res, input logic flush);
    @(negedge clk);
    InstrD = instr; PCD = pc_v; PCPlus4D = pc_v + 32'd4;
    RegWriteW = wr; RDW = rdw; ResultW = res; FlushE = flush;
    sb_q.push_back(model(instr, pc_v, wr, rdw, res, flush));
    if (wr && rdw != 5'd0) tb_rf[rdw] = res;
    pc_v = pc_v + 32'd4;
  endtask

  // Scoreboard monitor: compare after each capture edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("sb_ctrl", {24'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, 1'b0},
               {24'd0, e.rw, e.mw, e.j, e.br, e.asrc, e.rsrc, 1'b0});
      check_eq("sb_aluctl", {29'd0, ALUControlE}, {29'd0, e.actl});
      check_eq("sb_rd1", RD1E, e.rd1);
      check_eq("sb_rd2", RD2E, e.rd2);
      check_eq("sb_imm", ImmExtE, e.imm);
      check_eq("sb_pc", PCE, e.pc);
      check_eq("sb_pc4", PCPlus4E, e.pc4);
      check_eq("sb_regs", {17'd0, RdE, Rs1E, Rs2E}, {17'd0, e.rd, e.rs1, e.rs2});
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctrl"}, {22'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE}, 32'd0);
    check_eq({tag, "_rd1"}, RD1E, 32'd0);
    check_eq({tag, "_rd2"}, RD2E, 32'd0);
    check_eq({tag, "_imm"}, ImmExtE, 32'd0);
    check_eq({tag, "_pc"}, PCE | PCPlus4E, 32'd0);
    check_eq({tag, "_regs"}, {17'd0, RdE, Rs1E, Rs2E}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  ops [7];
    logic [31:0] r;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1110011};
    n_checks = 0; n_pass = 0; pc_v = 32'h0000_1000;
    for (int k = 0; k < 32; k++) tb_rf[k] = 32'd0;
    rst = 1'b0; InstrD = 32'd0; PCD = 32'd0; PCPlus4D = 32'd0;
    RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0; FlushE = 1'b0;

    // Reset held with random inputs, including register writes that must not land.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      InstrD = $urandom; PCD = $urandom; PCPlus4D = $urandom;
      RegWriteW = 1'b1; RDW = 5'd5; ResultW = $urandom; FlushE = 1'b0;
      @(posedge clk); #1;
      check_all_zero("reset");
      check_eq("reset_rs1d", {27'd0, Rs1D}, {27'd0, InstrD[19:15]});
    end
    @(negedge clk);
    rst = 1'b1; RegWriteW = 1'b0; RDW = 5'd0;

    cyc(32'h00000033, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    check_eq("r0_rd1", RD1E, 32'd0);
    check_eq("r0_rd2", RD2E, 32'd0);
    check_eq("r0_rw", {31'd0, RegWriteE}, 32'd1);
    check_eq("r0_rd", {27'd0, RdE}, 32'd0);

    cyc(32'h00000013, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    cyc(32'h00028333, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    check_eq("add_rd1", RD1E, 32'hDEADBEEF);
    check_eq("add_rd2", RD2E, 32'd0);
    check_eq("add_rw", {31'd0, RegWriteE}, 32'd1);
    check_eq("add_alu", {29'd0, ALUControlE}, 32'd0);
    check_eq("add_asrc", {31'd0, ALUSrcE}, 32'd0);
    check_eq("add_rd", {27'd0, RdE}, 32'd6);
    check_eq("add_rs1", {27'd0, Rs1E}, 32'd5);

    cyc(32'h00028333, 1'b1, 5'd5, 32'h12345678, 1'b0);
    @(posedge clk); #1;
    check_eq("bypass_rd1", RD1E, 32'h12345678);
    cyc(32'h00028333, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    check_eq("bypass_commit", RD1E, 32'h12345678);

    cyc(32'h00000033, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    @(posedge clk); #1;
    check_eq("x0_bypass", RD1E, 32'd0);
    cyc(32'h00000033, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    check_eq("x0_read", RD1E, 32'd0);

    cyc(32'hFE208CE3, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    check_eq("beq_imm", ImmExtE, 32'hFFFFFFF8);
    check_eq("beq_br", {31'd0, BranchE}, 32'd1);
    check_eq("beq_alu", {29'd0, ALUControlE}, 32'd1);
    check_eq("beq_rw", {31'd0, RegWriteE}, 32'd0);
    check_eq("beq_rs", {22'd0, Rs1E, Rs2E}, {22'd0, 5'd1, 5'd2});

    cyc(32'h0040A383, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b1);
    @(posedge clk); #1;
    check_all_zero("flush");
    cyc(32'h0040A383, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    check_eq("lw_rw", {31'd0, RegWriteE}, 32'd1);
    check_eq("lw_rsrc", {30'd0, ResultSrcE}, 32'd1);
    check_eq("lw_asrc", {31'd0, ALUSrcE}, 32'd1);
    check_eq("lw_imm", ImmExtE, 32'd4);
    check_eq("lw_rd", {27'd0, RdE}, 32'd7);
    cyc(32'h00048033, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    check_eq("flush_wb_commit", RD1E, 32'hA5A5A5A5);

    // Random mix of all opcode classes, writebacks and occasional flushes.
    for (int k = 0; k < 60; k++) begin
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 6)];
      cyc(r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset in mid-cycle clears outputs without a clock edge.
    @(posedge clk); #3;
    rst = 1'b0; InstrD = 32'h00A5_8000;
    #1;
    check_all_zero("async_rst");
    check_eq("async_rs1d", {27'd0, Rs1D}, {27'd0, InstrD[19:15]});
    check_eq("async_rs2d", {27'd0, Rs2D}, {27'd0, InstrD[24:20]});
    check_eq("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
